// File: rtl/display_pkg.sv
// Shared definitions for the timer display block.
// Provides the conversion state enum, the default widths and the blank
// segment pattern. It also provides the per-nibble double-dabble
// adjustment used by the binary-to-BCD converter.
package display_pkg;

    localparam int VALUE_W_DEF    = 11;
    localparam int NUM_DIGITS_DEF = 4;

    // Active-low segments: all ones turns every segment off.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH
    } state_t;

    // Add 3 to a BCD nibble of 5 or more. After the following left shift,
    // the nibble then carries correctly into the next decimal digit.
    function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/seven_seg.sv
// BCD digit to seven-segment decoder (purely combinational).
// Ports:
//   bcd - 4-bit BCD digit; the values 10..15 display blank
//   seg - active-low segments, bit0 = a through bit6 = g
module seven_seg
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/timer_display.sv
// Binary timer value to a BCD and seven-segment display.
// The block uses the sequential double-dabble method: one shift step per
// clock for VALUE_W clocks, then one latch cycle.
// The state table below is for the FSM in this file:
//   state    | meaning
//   ST_IDLE  | ready high; the block waits for value_valid
//   ST_SHIFT | one add-3/shift step per clock, VALUE_W steps in total
//   ST_LATCH | the block copies the accumulator to bcd/hex and pulses done
// Ports:
//   clk, reset_n        - clock; asynchronous active-low reset
//   value, value_valid  - binary count offered to the block; accepted while ready is high
//   blank_lz            - blank leading zeros, captured together with value
//   ready, done         - ready for a new value / one-cycle update pulse
//   bcd                 - latched BCD result, digit 0 in bits [3:0]
//   hex0..hex3          - registered active-low segment outputs, one per digit
// NUM_DIGITS must be at least 4 because the block drives hex0..hex3.
module timer_display
    import display_pkg::*;
#(
    parameter int VALUE_W    = VALUE_W_DEF,
    parameter int NUM_DIGITS = NUM_DIGITS_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [VALUE_W-1:0]      value,
    input  logic                    value_valid,
    input  logic                    blank_lz,
    output logic                    ready,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic [6:0]              hex0,
    output logic [6:0]              hex1,
    output logic [6:0]              hex2,
    output logic [6:0]              hex3
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(VALUE_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(VALUE_W - 1);

    state_t              state, state_nxt;
    logic [VALUE_W-1:0]  bin_q;
    logic [BCD_W-1:0]    acc_q;
    logic [BCD_W-1:0]    acc_adj;
    logic [CNT_W-1:0]    cnt_q;
    logic                blank_q;
    logic [NUM_DIGITS-1:0] blank_dig;
    logic [6:0]          seg_raw [NUM_DIGITS];
    logic [6:0]          hex_q   [NUM_DIGITS];
    logic                accept;

    assign accept = (state == ST_IDLE) && value_valid;

    always_comb begin
        acc_adj = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            acc_adj[4*i +: 4] = dabble_adj(acc_q[4*i +: 4]);
        end
    end

    // A digit is blanked when it and every digit above it are zero.
    // Digit 0 is never blanked, so a value of zero still shows "0".
    always_comb begin
        logic zero_run;
        blank_dig = '0;
        zero_run  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run     = zero_run && (acc_q[4*k +: 4] == 4'd0);
            blank_dig[k] = blank_q && (k != 0) && zero_run;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_seg
        seven_seg u_seg (
            .bcd (acc_q[4*g +: 4]),
            .seg (seg_raw[g])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (value_valid)        state_nxt = ST_SHIFT;
            ST_SHIFT: if (cnt_q == LAST_STEP) state_nxt = ST_LATCH;
            ST_LATCH:                         state_nxt = ST_IDLE;
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            blank_q <= 1'b0;
            ready   <= 1'b1;
            done    <= 1'b0;
            bcd     <= '0;
            for (int k = 0; k < NUM_DIGITS; k++) hex_q[k] <= SEG_BLANK;
        end else begin
            // The ready output is registered from the next state, so it
            // always equals (state == ST_IDLE).
            ready <= (state_nxt == ST_IDLE);
            done  <= (state == ST_LATCH);
            if (accept) begin
                bin_q   <= value;
                blank_q <= blank_lz;
                acc_q   <= '0;
                cnt_q   <= '0;
            end else if (state == ST_SHIFT) begin
                acc_q <= {acc_adj[BCD_W-2:0], bin_q[VALUE_W-1]};
                bin_q <= {bin_q[VALUE_W-2:0], 1'b0};
                cnt_q <= cnt_q + 1'b1;
            end else if (state == ST_LATCH) begin
                bcd <= acc_q;
                for (int k = 0; k < NUM_DIGITS; k++)
                    hex_q[k] <= blank_dig[k] ? SEG_BLANK : seg_raw[k];
            end
        end
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];

endmodule

// File: tb/tb_timer_display.sv
module tb_timer_display;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] value;
    logic        value_valid;
    logic        blank_lz;
    logic        ready;
    logic        done;
    logic [15:0] bcd;
    logic [6:0]  hex0, hex1, hex2, hex3;

    int passed = 0;
    int total  = 0;

    localparam logic [6:0] SEG_TAB [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [6:0] BLANK = 7'b1111111;

    timer_display dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .value       (value),
        .value_valid (value_valid),
        .blank_lz    (blank_lz),
        .ready       (ready),
        .done        (done),
        .bcd         (bcd),
        .hex0        (hex0),
        .hex1        (hex1),
        .hex2        (hex2),
        .hex3        (hex3)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int pow10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [15:0] exp_bcd(input int v);
        logic [15:0] r = '0;
        int t = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input bit bl, input int k);
        if (bl && k > 0 && v < pow10(k)) return BLANK;
        return SEG_TAB[(v / pow10(k)) % 10];
    endfunction

    function automatic logic [6:0] hex_of(input int k);
        case (k)
            0:       return hex0;
            1:       return hex1;
            2:       return hex2;
            default: return hex3;
        endcase
    endfunction

    task automatic check_out(input int v, input bit bl, input string tag);
        chk({tag, "_bcd"}, bcd, exp_bcd(v));
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s_hex%0d", tag, k), hex_of(k), exp_seg(v, bl, k));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, ready, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_bcd"}, bcd, 0);
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s_hex%0d", tag, k), hex_of(k), BLANK);
    endtask

    // Count edges until done is seen. While the conversion is busy, ready must stay low.
    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (n < 40) begin
            step();
            n++;
            if (done) break;
            chk({tag, "_busy_ready"}, ready, 0);
        end
        chk({tag, "_done_seen"}, done, 1);
    endtask

    task automatic convert(input int v, input bit bl, input string tag);
        int n;
        logic [15:0] held;
        value       = 11'(v);
        blank_lz    = bl;
        value_valid = 1'b1;
        step();
        value_valid = 1'b0;
        wait_done(tag, n);
        chk({tag, "_latency"}, n, 12);
        chk({tag, "_ready_with_done"}, ready, 1);
        check_out(v, bl, tag);
        held = bcd;
        step();
        chk({tag, "_done_one_cycle"}, done, 0);
        chk({tag, "_bcd_held"}, bcd, exp_bcd(v));
    endtask

    initial begin
        int n, n2, v;
        bit seen;
        reset_n     = 1'b1;
        value       = '0;
        value_valid = 1'b0;
        blank_lz    = 1'b0;
        #2 reset_n  = 1'b0;
        #1;
        check_reset_outputs("rst");
        repeat (3) step();
        check_reset_outputs("rst_hold");
        reset_n = 1'b1;

        convert(2047, 1'b0, "v2047");
        chk("v2047_bcd_const", bcd, 16'h2047);
        convert(0, 1'b1, "v0_blank");

        // Inputs offered during a conversion must be ignored.
        value = 11'd105; blank_lz = 1'b1; value_valid = 1'b1;
        step();
        value_valid = 1'b0;
        repeat (2) step();
        value = 11'd7; blank_lz = 1'b0; value_valid = 1'b1;
        repeat (5) step();
        value_valid = 1'b0;
        wait_done("v105", n);
        chk("v105_latency", n, 5);
        check_out(105, 1'b1, "v105");
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (done) seen = 1'b1;
        end
        chk("v105_no_queued_done", seen, 0);
        chk("v105_bcd_stable", bcd, 16'h0105);
        convert(7, 1'b0, "v7_after");

        // A reset during a conversion aborts it.
        value = 11'd999; blank_lz = 1'b0; value_valid = 1'b1;
        step();
        value_valid = 1'b0;
        repeat (5) step();
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done) seen = 1'b1;
        end
        chk("midrst_no_done", seen, 0);
        reset_n = 1'b1;
        convert(999, 1'b0, "v999_post_rst");

        // Back-to-back accepts while value_valid stays high.
        value = 11'd10; blank_lz = 1'b0; value_valid = 1'b1;
        step();
        value = 11'd5;
        wait_done("b2b_a", n);
        chk("b2b_a_latency", n, 12);
        check_out(10, 1'b0, "b2b_a");
        wait_done("b2b_b", n2);
        value_valid = 1'b0;
        chk("b2b_gap", n2, 13);
        check_out(5, 1'b0, "b2b_b");
        step();

        for (int i = 0; i < 2048; i++)
            convert(i, 1'($urandom_range(0, 1)), $sformatf("sweep%0d", i));

        for (int i = 0; i < 20; i++) begin
            v = int'($urandom_range(0, 2047));
            convert(v, 1'($urandom_range(0, 1)), $sformatf("rand%0d", v));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/timer_display.md
TIMER_DISPLAY -- requirements
Module: timer_display

Interface
REQ-001 SHALL have parameter VALUE_W, default 11, meaning width of the binary timer value.
REQ-002 SHALL have parameter NUM_DIGITS, default 4, meaning number of BCD digits and HEX outputs.
REQ-003 SHALL have port clk, input, 1, meaning the single clock (CLOCK_50 domain).
REQ-004 SHALL have port reset_n, input, 1, meaning reset, asynchronous and active-low.
REQ-005 SHALL have port value, input, VALUE_W, meaning the unsigned binary timer count to display.
REQ-006 SHALL have port value_valid, input, 1, meaning value is offered this cycle.
REQ-007 SHALL have port blank_lz, input, 1, meaning blank leading zeros when high.
REQ-008 SHALL have port ready, output, 1, meaning a new value can be accepted.
REQ-009 SHALL have port done, output, 1, meaning a one-cycle pulse when the display has been updated.
REQ-010 SHALL have port bcd, output, 4*NUM_DIGITS, meaning the latched BCD result, digit 0 in bits [3:0].
REQ-011 SHALL have ports hex0..hex3, output, 7 each, meaning active-low segments with bit0=a through bit6=g.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and LATCH.
REQ-013 SHALL assert ready only in IDLE; a value is accepted on an edge where value_valid and ready are both high.
REQ-014 SHALL, on accept, load value and blank_lz into working registers, clear the BCD accumulator and shift count, and go to SHIFT.
REQ-015 SHALL, in SHIFT, perform one double-dabble step per clock: add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by one.
REQ-016 SHALL leave SHIFT after exactly VALUE_W steps and go to LATCH.
REQ-017 SHALL, in LATCH, copy the accumulator to bcd, update hex0..hex3, pulse done for exactly one cycle, and return to IDLE.
REQ-018 SHALL assert done on the 12th rising edge after the accepting edge (VALUE_W+1 edges) for the default parameters; ready SHALL rise in the same cycle.
REQ-019 SHALL ignore value_valid while not in IDLE, with no queuing and no effect on the conversion in progress.
REQ-020 SHALL hold bcd and hex0..hex3 stable between LATCH events.
REQ-021 SHALL convert every value from 0 to 2047 exactly; the BCD accumulator SHALL never exceed 9 in any nibble after a step.
REQ-022 SHALL, when blank_lz is latched high, drive digit k (k>=1) to blank (7'b1111111) if digits k..NUM_DIGITS-1 are all zero; hex0 SHALL never be blanked.
REQ-023 SHALL use these segment codes for 0-9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000; any nibble >9 SHALL display blank.

Reset
REQ-024 SHALL, while reset_n is low, force state IDLE, ready=1, done=0, bcd=0, hex0..hex3=7'b1111111, and clear all working registers.
REQ-025 SHALL abort any conversion when reset is asserted mid-operation, with no done pulse and no partial update of bcd or the hex outputs.
REQ-026 SHALL accept a new value on the first rising edge after reset_n deasserts.

Structure
REQ-027 SHALL take the state enum, VALUE_W/NUM_DIGITS defaults and the SEG_BLANK constant from shared package display_pkg.
REQ-028 SHALL instantiate one combinational sub-module seven_seg (4-bit BCD to 7-bit active-low) once per digit.
REQ-029 SHALL register all outputs; seven_seg outputs SHALL be captured in the LATCH state.

Verification
REQ-030 Bench: value=2047 accepted with blank_lz=0 -> done exactly 12 edges later, bcd=16'h2047, hex3=0100100, hex2=1000000, hex1=0011001, hex0=1111000.
REQ-031 Bench: value=0, blank_lz=1 -> hex0=1000000, hex1..hex3=1111111, bcd=0.
REQ-032 Bench: value=105, blank_lz=1, then value_valid=1 with value=7 held for 5 cycles during SHIFT -> result is bcd=16'h0105, hex3 blank, hex2=1000000 (inner zero not blanked); 7 is converted only after ready returns.
REQ-033 Bench: reset_n pulsed low at step 6 of converting 999 -> no done pulse, outputs at reset values, ready=1; next accept of 999 yields bcd=16'h0999.
REQ-034 Bench: back-to-back accepts of 10 then 5 (value_valid held high) -> two done pulses exactly 13 edges apart (LATCH cycle plus 12-edge conversion), final bcd=16'h0005.
REQ-035 Bench: sweep all values 0..2047 -> bcd matches the reference decimal for every value; ready and done are never high together outside the LATCH-exit cycle.
